bf_mem_arbiter: RTL and testbench

//  Shares one DEPTH x DW register bank (decoder LLR/bit-state store) between

---
 rtl/bf_mem_arbiter_if.sv | 28 ++
 rtl/bf_mem_arbiter.sv | 109 ++++++++++
 tb/tb_bf_mem_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bf_mem_arbiter_if.sv
// Requester-side bus of the bit-flipping decoder state-bank arbiter.
// Carries the request/grant handshake, read return and bulk-clear control.
interface bf_mem_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic               rvalid;
  logic [DW-1:0]      rdata;
  logic               clr_start;
  logic               clr_done;
  logic               busy;

  modport master (
    output req, we, addr, wdata, clr_start,
    input  gnt, rvalid, rdata, clr_done, busy
  );

  modport slave (
    input  req, we, addr, wdata, clr_start,
    output gnt, rvalid, rdata, clr_done, busy
  );
endinterface

// File: rtl/bf_mem_arbiter.sv
// Shared LLR/bit-state bank arbiter with bulk clear for the LDPC BF decoder.
// Define BF_MEM_ARB_RR_EN for round-robin; default is fixed priority.
module bf_mem_arbiter #(
  parameter int NREQ  = 4,
  parameter int AW    = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input logic             clk,
  input logic             rst,
  bf_mem_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          st;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   clr_cnt;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [PW-1:0]   win;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdat;
  logic            wwe;
  logic            hit;
  int              idx;

`ifdef BF_MEM_ARB_RR_EN
  logic [PW-1:0]   ptr;
`endif

  // a requester granted last cycle sits out one cycle
  assign elig = bus.req & ~bus.gnt;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef BF_MEM_ARB_RR_EN
      idx = (int'(ptr) + 1 + k) % NREQ;
`else
      idx = k;
`endif
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign waddr = bus.addr[win*AW +: AW];
  assign wdat  = bus.wdata[win*DW +: DW];
  assign wwe   = bus.we[win];
  assign hit   = {{(32-AW){1'b0}}, waddr} < DEPTH;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st           <= IDLE;
      clr_cnt      <= '0;
      bus.gnt      <= '0;
      bus.rvalid   <= 1'b0;
      bus.rdata    <= '0;
      bus.clr_done <= 1'b0;
      bus.busy     <= 1'b0;
`ifdef BF_MEM_ARB_RR_EN
      ptr          <= PW'(NREQ-1);
`endif
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      bus.gnt      <= '0;
      bus.rvalid   <= 1'b0;
      bus.clr_done <= 1'b0;
      unique case (st)
        IDLE: begin
          if (bus.clr_start) begin
            st       <= CLEAR;
            bus.busy <= 1'b1;
            clr_cnt  <= '0;
          end else if (found) begin
            bus.gnt[win] <= 1'b1;
`ifdef BF_MEM_ARB_RR_EN
            ptr <= win;
`endif
            if (wwe) begin
              if (hit)
                mem[waddr] <= wdat;
            end else begin
              bus.rvalid <= 1'b1;
              bus.rdata  <= hit ? mem[waddr] : '0;
            end
          end
        end
        CLEAR: begin
          mem[clr_cnt] <= '0;
          if (clr_cnt == AW'(DEPTH-1)) begin
            st           <= IDLE;
            bus.busy     <= 1'b0;
            bus.clr_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bf_mem_arbiter.sv
// Directed bench for bf_mem_arbiter: access, arbitration, clear, reset.
// Arbitration expectations follow BF_MEM_ARB_RR_EN when defined.
module tb_bf_mem_arbiter;
  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  bf_mem_arbiter_if #(.NREQ(4), .AW(4), .DW(8)) bus ();

  bf_mem_arbiter #(
    .NREQ(4), .AW(4), .DW(8), .DEPTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input int i, input logic w,
                     input logic [3:0] a, input logic [7:0] d,
                     output logic [7:0] q, output logic rv);
    logic ok;
    bus.req[i]          = 1'b1;
    bus.we[i]           = w;
    bus.addr[i*4 +: 4]  = a;
    bus.wdata[i*8 +: 8] = d;
    ok = 1'b0;
    for (int n = 0; n < 8 && !ok; n++) begin
      tick();
      if (bus.gnt[i]) ok = 1'b1;
    end
    chk("acc gnt seen", 32'(ok), 32'd1);
    q  = bus.rdata;
    rv = bus.rvalid;
    bus.req[i] = 1'b0;
  endtask

  task automatic fill(input logic [7:0] d);
    logic [7:0] q;
    logic       rv;
    for (int a = 0; a < 16; a++)
      acc(0, 1'b1, 4'(a), d, q, rv);
  endtask

  task automatic read_all_zero(input string tag);
    logic [7:0] q;
    logic       rv;
    for (int a = 0; a < 16; a++) begin
      acc(0, 1'b0, 4'(a), 8'h00, q, rv);
      chk(tag, 32'(q), 32'h0);
    end
  endtask

  logic [7:0] q;
  logic       rv;
  int         bcnt;
  int         dpos;
  logic [3:0] gacc;
  int         exp_g [6];

  initial begin
    nvec = 0;
    nerr = 0;
    rst  = 1'b0;
    bus.req = '0; bus.we = '0; bus.addr = '0;
    bus.wdata = '0; bus.clr_start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst gnt",    32'(bus.gnt),      32'h0);
    chk("rst rvalid", 32'(bus.rvalid),   32'h0);
    chk("rst rdata",  32'(bus.rdata),    32'h0);
    chk("rst busy",   32'(bus.busy),     32'h0);
    chk("rst done",   32'(bus.clr_done), 32'h0);

    // T1 write then read back
    bus.req[0] = 1'b1; bus.we[0] = 1'b1;
    bus.addr[3:0] = 4'd3; bus.wdata[7:0] = 8'hA5;
    tick();
    chk("t1 wr gnt",    32'(bus.gnt),    32'h1);
    chk("t1 wr rvalid", 32'(bus.rvalid), 32'h0);
    bus.req[0] = 1'b0;
    tick();
    acc(0, 1'b0, 4'd3, 8'h00, q, rv);
    chk("t1 rd rdata",  32'(q),  32'hA5);
    chk("t1 rd rvalid", 32'(rv), 32'h1);

    // T2 read of untouched entry
    bus.req[1] = 1'b1; bus.we[1] = 1'b0; bus.addr[7:4] = 4'd7;
    tick();
    chk("t2 gnt",    32'(bus.gnt),   32'h2);
    chk("t2 rdata",  32'(bus.rdata), 32'h0);
    chk("t2 rvalid", 32'(bus.rvalid), 32'h1);
    bus.req[1] = 1'b0;
    tick();
    chk("t2 rvalid drop", 32'(bus.rvalid), 32'h0);
    chk("t2 rdata hold",  32'(bus.rdata),  32'h0);

    // T3 all requesters held, fresh pointer
    rst = 1'b0; tick(); rst = 1'b1; tick();
`ifdef BF_MEM_ARB_RR_EN
    exp_g = '{0, 1, 2, 3, 0, 1};
`else
    exp_g = '{0, 1, 0, 1, 0, 1};
`endif
    bus.we = '0; bus.addr = '0; bus.req = 4'hF;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t3 gnt %0d", k), 32'(bus.gnt), 32'(1 << exp_g[k]));
    end
    bus.req = '0;
    tick();

    // T4 fill, clear with req[2] pending
    fill(8'h11);
    acc(0, 1'b0, 4'd9, 8'h00, q, rv);
    chk("t4 fill rd", 32'(q), 32'h11);
    tick();
    bus.clr_start = 1'b1;
    bus.req[2] = 1'b1; bus.we[2] = 1'b0; bus.addr[11:8] = 4'd5;
    tick();
    bus.clr_start = 1'b0;
    chk("t4 no gnt at start", 32'(bus.gnt), 32'h0);
    bcnt = bus.busy ? 1 : 0;
    gacc = bus.gnt;
    dpos = -1;
    for (int k = 1; k <= 20 && dpos < 0; k++) begin
      bus.clr_start = (k == 8);
      tick();
      if (bus.busy) bcnt++;
      gacc |= bus.gnt;
      if (bus.clr_done) dpos = k;
    end
    bus.clr_start = 1'b0;
    chk("t4 busy cycles", 32'(bcnt), 32'd16);
    chk("t4 done pos",    32'(dpos), 32'd16);
    chk("t4 gnt in clr",  32'(gacc), 32'h0);
    chk("t4 busy low",    32'(bus.busy), 32'h0);
    tick();
    chk("t4 gnt2 after", 32'(bus.gnt),   32'h4);
    chk("t4 gnt2 rdata", 32'(bus.rdata), 32'h0);
    bus.req[2] = 1'b0;
    tick();
    read_all_zero("t4 clr rd");

    // T5 reset in the middle of a clear
    fill(8'h11);
    tick();
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("t5 busy before rst", 32'(bus.busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("t5 busy async", 32'(bus.busy),     32'h0);
    chk("t5 done async", 32'(bus.clr_done), 32'h0);
    tick();
    rst = 1'b1;
    dpos = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.clr_done || bus.busy) dpos++;
    end
    chk("t5 no done/busy", 32'(dpos), 32'd0);
    read_all_zero("t5 clr rd");

    // T6 write then read same address on consecutive edges
    bus.req[1] = 1'b1; bus.we[1] = 1'b1;
    bus.addr[7:4] = 4'd15; bus.wdata[15:8] = 8'h3C;
    bus.req[3] = 1'b1; bus.we[3] = 1'b0; bus.addr[15:12] = 4'd15;
    tick();
    chk("t6 wr gnt", 32'(bus.gnt), 32'h2);
    bus.req[1] = 1'b0;
    tick();
    chk("t6 rd gnt",    32'(bus.gnt),    32'h8);
    chk("t6 rd rdata",  32'(bus.rdata),  32'h3C);
    chk("t6 rd rvalid", 32'(bus.rvalid), 32'h1);
    bus.req[3] = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
